// File: rtl/clk_pattern_sched.sv
// Multi-channel programmable clock/pulse scheduler with shadowed, glitch-free config updates.
// Optional build macro CLK_PATTERN_PERIOD_CNT_EN adds a per-channel 16-bit period_cnt output.
module clk_pattern_sched #(
  parameter int NCH = 2,
  parameter int CW  = 16,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [CW-1:0]    cfg_period,
  input  logic [CW-1:0]    cfg_ton,
  input  logic [CW-1:0]    cfg_phase,
  output logic             cfg_err,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   active
`ifdef CLK_PATTERN_PERIOD_CNT_EN
  ,
  output logic [NCH*16-1:0] period_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, PHASE, RUN} state_t;

  logic [NCH-1:0]        pending;
  logic [(1<<CHW)-1:0]   pend_ext;
  logic                  ch_ok;
  logic                  cfg_legal;
  logic                  cfg_fire;

  // Out-of-range channels read as not-pending so the request is taken and flagged as an error.
  always_comb begin
    pend_ext = '0;
    pend_ext[NCH-1:0] = pending;
  end

  assign ch_ok     = ({1'b0, cfg_ch} < (CHW+1)'(NCH));
  assign cfg_ready = !rst && !pend_ext[cfg_ch];
  assign cfg_legal = ch_ok && (cfg_period >= CW'(2));
  assign cfg_fire  = cfg_valid && cfg_ready;

  always_ff @(posedge clk) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= cfg_fire && !cfg_legal;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] sh_per, sh_ton, sh_ph;
    logic [CW-1:0] ac_per, ac_ton, ac_ph;
    logic [CW-1:0] next_ph;
    logic          pend, co, act, wr;

    assign wr         = cfg_fire && cfg_legal && (cfg_ch == CHW'(i));
    assign next_ph    = pend ? sh_ph : ac_ph;
    assign pending[i] = pend;
    assign clk_out[i] = co;
    assign active[i]  = act;

`ifdef CLK_PATTERN_PERIOD_CNT_EN
    logic [15:0] pcnt;
    assign period_cnt[16*i +: 16] = pcnt;
`endif

    // Shadow registers only reach the active set in IDLE or at a RUN period wrap.
    always_ff @(posedge clk) begin
      if (rst) begin
        state  <= IDLE;
        cnt    <= '0;
        co     <= 1'b0;
        act    <= 1'b0;
        pend   <= 1'b0;
        sh_per <= CW'(2);
        sh_ton <= CW'(1);
        sh_ph  <= '0;
        ac_per <= CW'(2);
        ac_ton <= CW'(1);
        ac_ph  <= '0;
`ifdef CLK_PATTERN_PERIOD_CNT_EN
        pcnt   <= '0;
`endif
      end else begin
        if (!en[i]) begin
          state <= IDLE;
          cnt   <= '0;
          co    <= 1'b0;
          act   <= 1'b0;
          if (state == IDLE && pend) begin
            ac_per <= sh_per;
            ac_ton <= sh_ton;
            ac_ph  <= sh_ph;
            pend   <= 1'b0;
          end
        end else begin
          case (state)
            IDLE: begin
              if (pend) begin
                ac_per <= sh_per;
                ac_ton <= sh_ton;
                ac_ph  <= sh_ph;
                pend   <= 1'b0;
              end
              cnt   <= '0;
              co    <= 1'b0;
              act   <= 1'b1;
              state <= (next_ph != '0) ? PHASE : RUN;
            end
            PHASE: begin
              co <= 1'b0;
              if (cnt == ac_ph - CW'(1)) begin
                cnt   <= '0;
                state <= RUN;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
            RUN: begin
              co <= (cnt < ac_ton);
              if (cnt == ac_per - CW'(1)) begin
                cnt <= '0;
`ifdef CLK_PATTERN_PERIOD_CNT_EN
                pcnt <= pcnt + 16'd1;
`endif
                if (pend) begin
                  ac_per <= sh_per;
                  ac_ton <= sh_ton;
                  ac_ph  <= sh_ph;
                  pend   <= 1'b0;
                end
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
            default: state <= IDLE;
          endcase
        end
        if (wr) begin
          sh_per <= cfg_period;
          sh_ton <= cfg_ton;
          sh_ph  <= cfg_phase;
          pend   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_pattern_sched.sv
// Self-checking bench for clk_pattern_sched: scenario tasks plus randomized traffic vs a position-based model.
// Honours CLK_PATTERN_PERIOD_CNT_EN when the design is built with it.
module tb_clk_pattern_sched;
  localparam int NCH = 3;
  localparam int CW  = 16;
  localparam int CHW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NCH-1:0]  en = '0;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [CHW-1:0]  cfg_ch = '0;
  logic [CW-1:0]   cfg_period = 16'd2;
  logic [CW-1:0]   cfg_ton = 16'd1;
  logic [CW-1:0]   cfg_phase = 16'd0;
  logic            cfg_err;
  logic [NCH-1:0]  clk_out;
  logic [NCH-1:0]  active;
`ifdef CLK_PATTERN_PERIOD_CNT_EN
  logic [NCH*16-1:0] period_cnt;
`endif

  int n_checks = 0;
  int n_fail = 0;

  // Model: a channel is either off, or at output position m_pos (negative while idling through phase).
  bit m_on[NCH];
  bit m_pend[NCH];
  bit m_clk[NCH];
  bit m_err;
  int m_pos[NCH];
  int m_pc[NCH];
  int a_per[NCH], a_ton[NCH], a_ph[NCH];
  int s_per[NCH], s_ton[NCH], s_ph[NCH];

  clk_pattern_sched #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_ton(cfg_ton), .cfg_phase(cfg_phase),
    .cfg_err(cfg_err), .clk_out(clk_out), .active(active)
`ifdef CLK_PATTERN_PERIOD_CNT_EN
    , .period_cnt(period_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit m_ready();
    if (rst) return 1'b0;
    if (int'(cfg_ch) >= NCH) return 1'b1;
    return !m_pend[cfg_ch];
  endfunction

  function automatic logic [NCH-1:0] exp_clk();
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = m_clk[c];
    return r;
  endfunction

  function automatic logic [NCH-1:0] exp_act();
    logic [NCH-1:0] r;
    for (int c = 0; c < NCH; c++) r[c] = m_on[c];
    return r;
  endfunction

  function automatic logic [NCH*16-1:0] exp_pc();
    logic [NCH*16-1:0] r;
    for (int c = 0; c < NCH; c++) r[16*c +: 16] = 16'(m_pc[c]);
    return r;
  endfunction

  task automatic m_apply(input int c);
    a_per[c] = s_per[c];
    a_ton[c] = s_ton[c];
    a_ph[c]  = s_ph[c];
    m_pend[c] = 1'b0;
  endtask

  task automatic model_edge();
    bit fire, legal;
    bit old_pend[NCH];
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_on[c] = 0; m_pend[c] = 0; m_clk[c] = 0; m_pos[c] = 0; m_pc[c] = 0;
        a_per[c] = 2; a_ton[c] = 1; a_ph[c] = 0;
        s_per[c] = 2; s_ton[c] = 1; s_ph[c] = 0;
      end
      m_err = 0;
      return;
    end
    fire = cfg_valid && m_ready();
    legal = (int'(cfg_ch) < NCH) && (cfg_period >= 2);
    old_pend = m_pend;
    m_err = fire && !legal;
    for (int c = 0; c < NCH; c++) begin
      if (!en[c]) begin
        if (!m_on[c] && old_pend[c]) m_apply(c);
        m_on[c] = 0;
        m_clk[c] = 0;
      end else if (!m_on[c]) begin
        if (old_pend[c]) m_apply(c);
        m_on[c] = 1;
        m_pos[c] = -a_ph[c];
        m_clk[c] = 0;
      end else if (m_pos[c] < 0) begin
        m_clk[c] = 0;
        m_pos[c]++;
      end else begin
        m_clk[c] = (m_pos[c] < a_ton[c]);
        if (m_pos[c] == a_per[c] - 1) begin
          m_pos[c] = 0;
          m_pc[c] = (m_pc[c] + 1) % 65536;
          if (old_pend[c]) m_apply(c);
        end else begin
          m_pos[c]++;
        end
      end
    end
    if (fire && legal) begin
      s_per[cfg_ch] = int'(cfg_period);
      s_ton[cfg_ch] = int'(cfg_ton);
      s_ph[cfg_ch]  = int'(cfg_phase);
      m_pend[cfg_ch] = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_cfg(input int ch, input int per, input int ton, input int ph);
    cfg_ch = CHW'(ch);
    cfg_period = CW'(per);
    cfg_ton = CW'(ton);
    cfg_phase = CW'(ph);
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = '0; cfg_valid = 1'b0;
    repeat (3) begin
      step();
      n_checks++; if (clk_out !== '0) begin n_fail++; $display("[TB] FAIL reset clk_out got=%b exp=0", clk_out); end
      n_checks++; if (active !== '0) begin n_fail++; $display("[TB] FAIL reset active got=%b exp=0", active); end
      n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset cfg_ready got=%b exp=0", cfg_ready); end
    end
    rst = 1'b0;
    step();
    step();
    for (int c = 0; c < NCH; c++) begin
      cfg_ch = CHW'(c);
      #1;
      n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready ch=%0d got=%b exp=1", c, cfg_ready); end
    end
    cfg_ch = '0;
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset cfg_err got=%b exp=0", cfg_err); end
`ifdef CLK_PATTERN_PERIOD_CNT_EN
    n_checks++; if (period_cnt !== '0) begin n_fail++; $display("[TB] FAIL reset period_cnt got=%h exp=0", period_cnt); end
`endif
  endtask

  task automatic test_duty50();
    do_cfg(0, 10, 5, 0);
    en = 3'b001;
    step();
    n_checks++; if (active !== 3'b001) begin n_fail++; $display("[TB] FAIL duty50 active got=%b exp=001", active); end
    for (int k = 1; k <= 30; k++) begin
      step();
      n_checks++; if (clk_out[0] !== (((k - 1) % 10) < 5)) begin n_fail++; $display("[TB] FAIL duty50 k=%0d got=%b exp=%b", k, clk_out[0], ((k - 1) % 10) < 5); end
      n_checks++; if (clk_out !== exp_clk()) begin n_fail++; $display("[TB] FAIL duty50_model k=%0d got=%b exp=%b", k, clk_out, exp_clk()); end
    end
    en = '0;
    step(); step();
  endtask

  task automatic test_phase();
    bit h0[$];
    bit e1;
    do_cfg(0, 8, 4, 0);
    do_cfg(1, 8, 4, 3);
    en = 3'b011;
    step();
    for (int k = 1; k <= 40; k++) begin
      step();
      h0.push_back(clk_out[0]);
      e1 = (k >= 4) ? (((k - 4) % 8) < 4) : 1'b0;
      n_checks++; if (clk_out[1] !== e1) begin n_fail++; $display("[TB] FAIL phase ch1 k=%0d got=%b exp=%b", k, clk_out[1], e1); end
      if (k > 3) begin
        n_checks++; if (clk_out[1] !== h0[k - 4]) begin n_fail++; $display("[TB] FAIL phase_delay k=%0d got=%b exp=%b", k, clk_out[1], h0[k - 4]); end
      end
      n_checks++; if (clk_out !== exp_clk()) begin n_fail++; $display("[TB] FAIL phase_model k=%0d got=%b exp=%b", k, clk_out, exp_clk()); end
    end
    en = '0;
    step(); step();
  endtask

  task automatic test_live_update();
    bit e;
    do_cfg(0, 10, 5, 0);
    en = 3'b001;
    step();
    for (int k = 1; k <= 30; k++) begin
      cfg_ch = '0;
      if (k == 4) begin
        cfg_period = 16'd4; cfg_ton = 16'd1; cfg_phase = 16'd0; cfg_valid = 1'b1;
      end else if (k == 5 || k == 6) begin
        cfg_period = 16'd6; cfg_ton = 16'd2; cfg_phase = 16'd0; cfg_valid = 1'b1;
        #1;
        n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL live_stall k=%0d got=%b exp=0", k, cfg_ready); end
      end else begin
        cfg_valid = 1'b0;
      end
      step();
      cfg_valid = 1'b0;
      e = (k <= 10) ? (k <= 5) : (((k - 11) % 4) == 0);
      n_checks++; if (clk_out[0] !== e) begin n_fail++; $display("[TB] FAIL live_wave k=%0d got=%b exp=%b", k, clk_out[0], e); end
      n_checks++; if (cfg_ready !== !(k >= 4 && k <= 9)) begin n_fail++; $display("[TB] FAIL live_ready k=%0d got=%b exp=%b", k, cfg_ready, !(k >= 4 && k <= 9)); end
      n_checks++; if (clk_out !== exp_clk()) begin n_fail++; $display("[TB] FAIL live_model k=%0d got=%b exp=%b", k, clk_out, exp_clk()); end
    end
    en = '0;
    step(); step();
  endtask

  task automatic test_illegal();
    bit inj;
    do_cfg(0, 6, 2, 0);
    en = 3'b001;
    step();
    for (int k = 1; k <= 30; k++) begin
      inj = (k == 5 || k == 9 || k == 13);
      cfg_valid = inj;
      cfg_ton = 16'd3; cfg_phase = 16'd0;
      if (k == 5)       begin cfg_ch = 2'd0; cfg_period = 16'd1; end
      else if (k == 9)  begin cfg_ch = 2'd3; cfg_period = 16'd5; end
      else if (k == 13) begin cfg_ch = 2'd1; cfg_period = 16'd0; end
      else              begin cfg_ch = 2'd0; end
      step();
      cfg_valid = 1'b0;
      n_checks++; if (cfg_err !== inj) begin n_fail++; $display("[TB] FAIL illegal_err k=%0d got=%b exp=%b", k, cfg_err, inj); end
      n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL illegal_ready k=%0d got=%b exp=1", k, cfg_ready); end
      n_checks++; if (clk_out[0] !== (((k - 1) % 6) < 2)) begin n_fail++; $display("[TB] FAIL illegal_wave k=%0d got=%b exp=%b", k, clk_out[0], ((k - 1) % 6) < 2); end
    end
    cfg_ch = '0;
    en = '0;
    step(); step();
  endtask

  task automatic test_degenerate();
    do_cfg(2, 5, 0, 0);
    en = 3'b100;
    step();
    for (int k = 1; k <= 10; k++) begin
      step();
      n_checks++; if (clk_out[2] !== 1'b0 || active[2] !== 1'b1) begin n_fail++; $display("[TB] FAIL degen_low k=%0d clk=%b act=%b exp clk=0 act=1", k, clk_out[2], active[2]); end
    end
    en = '0;
    step();
    do_cfg(2, 5, 7, 1);
    n_checks++; if (cfg_err !== 1'b0) begin n_fail++; $display("[TB] FAIL degen_err got=%b exp=0", cfg_err); end
    en = 3'b100;
    step();
    for (int k = 1; k <= 12; k++) begin
      step();
      n_checks++; if (clk_out[2] !== (k >= 2)) begin n_fail++; $display("[TB] FAIL degen_high k=%0d got=%b exp=%b", k, clk_out[2], k >= 2); end
    end
    en = '0;
    step(); step();
  endtask

  task automatic test_abort();
    do_cfg(0, 10, 5, 0);
    en = 3'b001;
    step();
    for (int k = 1; k <= 23; k++) begin
      step();
      n_checks++; if (clk_out !== exp_clk()) begin n_fail++; $display("[TB] FAIL abort_run k=%0d got=%b exp=%b", k, clk_out, exp_clk()); end
    end
    en = '0;
    step();
    n_checks++; if (clk_out[0] !== 1'b0 || active[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_drop clk=%b act=%b exp 0 0", clk_out[0], active[0]); end
    repeat (3) step();
`ifdef CLK_PATTERN_PERIOD_CNT_EN
    n_checks++; if (period_cnt !== exp_pc()) begin n_fail++; $display("[TB] FAIL abort_pcnt_hold got=%h exp=%h", period_cnt, exp_pc()); end
`endif
    en = 3'b011;
    repeat (6) step();
    rst = 1'b1;
    step();
    n_checks++; if (clk_out !== '0 || active !== '0 || cfg_err !== 1'b0 || cfg_ready !== 1'b0) begin
      n_fail++; $display("[TB] FAIL abort_rst clk=%b act=%b err=%b rdy=%b exp all 0", clk_out, active, cfg_err, cfg_ready);
    end
`ifdef CLK_PATTERN_PERIOD_CNT_EN
    n_checks++; if (period_cnt !== '0) begin n_fail++; $display("[TB] FAIL abort_pcnt_rst got=%h exp=0", period_cnt); end
`endif
    rst = 1'b0;
    en = '0;
    step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < NCH; c++) if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
      cfg_valid  = ($urandom_range(0, 2) == 0);
      cfg_ch     = CHW'($urandom_range(0, 3));
      cfg_period = CW'($urandom_range(0, 12));
      cfg_ton    = CW'($urandom_range(0, 14));
      cfg_phase  = CW'($urandom_range(0, 4));
      rst        = ($urandom_range(0, 249) == 0);
      #1;
      n_checks++; if (cfg_ready !== m_ready()) begin n_fail++; $display("[TB] FAIL rand_ready n=%0d got=%b exp=%b", n, cfg_ready, m_ready()); end
      step();
      n_checks++; if (clk_out !== exp_clk()) begin n_fail++; $display("[TB] FAIL rand_clk n=%0d got=%b exp=%b", n, clk_out, exp_clk()); end
      n_checks++; if (active !== exp_act()) begin n_fail++; $display("[TB] FAIL rand_active n=%0d got=%b exp=%b", n, active, exp_act()); end
      n_checks++; if (cfg_err !== m_err) begin n_fail++; $display("[TB] FAIL rand_err n=%0d got=%b exp=%b", n, cfg_err, m_err); end
`ifdef CLK_PATTERN_PERIOD_CNT_EN
      n_checks++; if (period_cnt !== exp_pc()) begin n_fail++; $display("[TB] FAIL rand_pcnt n=%0d got=%h exp=%h", n, period_cnt, exp_pc()); end
`endif
    end
    rst = 1'b0;
    cfg_valid = 1'b0;
    en = '0;
    step();
  endtask

  initial begin
    test_reset();
    test_duty50();
    test_phase();
    test_live_update();
    test_illegal();
    test_degenerate();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
